pmem_arbiter: RTL and testbench

- Shares the single physical-memory port between the instruction cache and the data cache.
- Each cache presents its cache-line read/write request as if it owned physical memory.
- The arbiter grants one requester at a time (round-robin on conflict) and latches that request into a stable memory transaction.
- It routes the memory response back to the granted cache only.
- Sits between the two cache controllers and the physical-memory / cacheline-adapter interface.

---
 rtl/pmem_arbiter.sv | 105 ++++++++++
 tb/tb_pmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter that shares one physical-memory port between the I-cache and the D-cache.
// A granted request is latched so the memory sees a stable transaction until pmem_resp arrives.
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0]        state;
    logic              last_grant_d;
    logic              op_read;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic grant_d;

    // On a tie the side that was not served last wins.
    assign i_req   = i_pmem_read;
    assign d_req   = d_pmem_read | d_pmem_write;
    assign grant_d = d_req & (~i_req | ~last_grant_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            op_read      <= 1'b0;
            op_write     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= BUSY_D;
                        last_grant_d <= 1'b1;
                        addr_q       <= d_pmem_address;
                        op_write     <= d_pmem_write;
                        op_read      <= ~d_pmem_write;
                        if (d_pmem_write) begin
                            wdata_q <= d_pmem_wdata;
                        end
                    end else if (i_req) begin
                        state        <= BUSY_I;
                        last_grant_d <= 1'b0;
                        addr_q       <= i_pmem_address;
                        op_write     <= 1'b0;
                        op_read      <= 1'b1;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (pmem_resp) begin
                        state    <= IDLE;
                        op_read  <= 1'b0;
                        op_write <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    op_read  <= 1'b0;
                    op_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = op_read  & (state != IDLE);
    assign pmem_write   = op_write & (state != IDLE);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Responses and data reach only the side that owns the current transaction.
    assign i_pmem_resp  = (state == BUSY_I) & pmem_resp;
    assign d_pmem_resp  = (state == BUSY_D) & pmem_resp;
    assign i_pmem_rdata = (state == BUSY_I) ? pmem_rdata : '0;
    assign d_pmem_rdata = (state == BUSY_D) ? pmem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: inputs change 1ns after the rising edge, outputs are checked
// on the falling edge or 1ns after a combinational response input is applied.
module tb_pmem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks;
    int errors;

    pmem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ends a memory response: one edge with pmem_resp high, then deassert it 1ns later.
    task automatic end_resp();
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_pmem_read = 0; i_pmem_address = 0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = 0; d_pmem_wdata = 0;
        pmem_rdata = 0; pmem_resp = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b expected 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
        end
        checks++;
        if (pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
            errors++;
            $display("[TB] FAIL reset_latch got addr %h wdata %h expected 0", pmem_address, pmem_wdata);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_solo_i_read();
        i_pmem_read = 1; i_pmem_address = 32'h0000_1040;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++;
            $display("[TB] FAIL solo_i_idle got pmem_read %b expected 0", pmem_read);
        end
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_1040) begin
            errors++;
            $display("[TB] FAIL solo_i_busy got r %b w %b addr %h expected r 1 w 0 addr 00001040", pmem_read, pmem_write, pmem_address);
        end
        repeat (2) @(negedge clk);
        pmem_resp = 1; pmem_rdata = {32{8'hA5}};
        #1;
        checks++;
        if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== {32{8'hA5}}) begin
            errors++;
            $display("[TB] FAIL solo_i_resp got resp %b rdata %h expected 1 a5..a5", i_pmem_resp, i_pmem_rdata);
        end
        checks++;
        if (d_pmem_resp !== 1'b0 || d_pmem_rdata !== 256'h0) begin
            errors++;
            $display("[TB] FAIL solo_i_dside got resp %b rdata %h expected 0 0", d_pmem_resp, d_pmem_rdata);
        end
        end_resp();
        i_pmem_read = 0;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++;
            $display("[TB] FAIL solo_i_done got pmem_read %b expected 0", pmem_read);
        end
    endtask

    task automatic test_d_write_read();
        d_pmem_write = 1; d_pmem_address = 32'h2000; d_pmem_wdata = {8{32'h1234_5678}};
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h2000) begin
            errors++;
            $display("[TB] FAIL dwr_busy got r %b w %b addr %h expected r 0 w 1 addr 00002000", pmem_read, pmem_write, pmem_address);
        end
        d_pmem_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (pmem_wdata !== {8{32'h1234_5678}} || pmem_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dwr_stall got w %b wdata %h expected 1 12345678..", pmem_write, pmem_wdata);
        end
        pmem_resp = 1;
        #1;
        checks++;
        if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dwr_resp got d %b i %b expected d 1 i 0", d_pmem_resp, i_pmem_resp);
        end
        end_resp();
        d_pmem_write = 0; d_pmem_read = 1; d_pmem_address = 32'h3000;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drd_gap got r %b w %b expected 0 0", pmem_read, pmem_write);
        end
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h3000) begin
            errors++;
            $display("[TB] FAIL drd_busy got r %b w %b addr %h expected r 1 w 0 addr 00003000", pmem_read, pmem_write, pmem_address);
        end
        pmem_resp = 1; pmem_rdata = {32{8'h5A}};
        #1;
        checks++;
        if (d_pmem_resp !== 1'b1 || d_pmem_rdata !== {32{8'h5A}} || i_pmem_rdata !== 256'h0) begin
            errors++;
            $display("[TB] FAIL drd_resp got resp %b d %h i %h expected 1 5a..5a 0", d_pmem_resp, d_pmem_rdata, i_pmem_rdata);
        end
        end_resp();
        d_pmem_read = 0;
    endtask

    task automatic test_tie_order();
        logic [31:0] exp_addr;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        i_pmem_read = 1; i_pmem_address = 32'h100;
        d_pmem_read = 1; d_pmem_address = 32'h200;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 32'h200 : 32'h100;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (pmem_read !== 1'b1 || pmem_address !== exp_addr) begin
                errors++;
                $display("[TB] FAIL tie_grant%0d got r %b addr %h expected r 1 addr %h", k, pmem_read, pmem_address, exp_addr);
            end
            pmem_resp = 1;
            #1;
            checks++;
            if (d_pmem_resp !== (k % 2 == 0) || i_pmem_resp !== (k % 2 == 1)) begin
                errors++;
                $display("[TB] FAIL tie_resp%0d got d %b i %b expected d %b i %b", k, d_pmem_resp, i_pmem_resp, k % 2 == 0, k % 2 == 1);
            end
            end_resp();
        end
        i_pmem_read = 0; d_pmem_read = 0;
    endtask

    task automatic test_mid_change();
        i_pmem_read = 1; i_pmem_address = 32'h100;
        @(negedge clk);
        @(negedge clk);
        i_pmem_address = 32'h180; d_pmem_write = 1; d_pmem_address = 32'h400;
        d_pmem_wdata = {8{32'hDEAD_BEEF}};
        repeat (2) @(negedge clk);
        checks++;
        if (pmem_address !== 32'h100 || pmem_write !== 1'b0 || pmem_read !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_hold got r %b w %b addr %h expected r 1 w 0 addr 00000100", pmem_read, pmem_write, pmem_address);
        end
        pmem_resp = 1;
        #1;
        checks++;
        if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_resp got i %b d %b expected i 1 d 0", i_pmem_resp, d_pmem_resp);
        end
        end_resp();
        i_pmem_read = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1 || pmem_address !== 32'h400 || pmem_wdata !== {8{32'hDEAD_BEEF}}) begin
            errors++;
            $display("[TB] FAIL mid_next got w %b addr %h wdata %h expected 1 00000400 deadbeef..", pmem_write, pmem_address, pmem_wdata);
        end
        pmem_resp = 1;
        end_resp();
        d_pmem_write = 0;
    endtask

    task automatic test_reset_busy_d();
        d_pmem_read = 1; d_pmem_address = 32'h600;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h600) begin
            errors++;
            $display("[TB] FAIL rstd_busy got r %b addr %h expected 1 00000600", pmem_read, pmem_address);
        end
        @(posedge clk);
        #1 rst = 1; d_pmem_read = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstd_abort got r %b w %b expected 0 0", pmem_read, pmem_write);
        end
        pmem_resp = 1; pmem_rdata = {32{8'h77}};
        #1;
        checks++;
        if (d_pmem_resp !== 1'b0 || d_pmem_rdata !== 256'h0 || i_pmem_resp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstd_stale got d %b drdata %h i %b expected 0 0 0", d_pmem_resp, d_pmem_rdata, i_pmem_resp);
        end
        end_resp();
        i_pmem_read = 1; i_pmem_address = 32'h100;
        d_pmem_read = 1; d_pmem_address = 32'h200;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h200) begin
            errors++;
            $display("[TB] FAIL rstd_tie got r %b addr %h expected 1 00000200", pmem_read, pmem_address);
        end
        pmem_resp = 1;
        end_resp();
        i_pmem_read = 0; d_pmem_read = 0;
    endtask

    task automatic test_read_write_both();
        d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h800;
        d_pmem_wdata = {8{32'hCAFE_F00D}};
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_wdata !== {8{32'hCAFE_F00D}}) begin
            errors++;
            $display("[TB] FAIL rw_both got r %b w %b wdata %h expected r 0 w 1 cafef00d..", pmem_read, pmem_write, pmem_wdata);
        end
        pmem_resp = 1;
        end_resp();
        d_pmem_read = 0; d_pmem_write = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_solo_i_read();
        test_d_write_read();
        test_tie_order();
        test_mid_change();
        test_reset_busy_d();
        test_read_write_both();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
